// File: rtl/pipe_ctrl.sv
// Hazard and stall controller for the 5-stage core: load-use bubbles, branch squash,
// data-memory freeze and memory-timeout halt.
module pipe_ctrl #(
  parameter int RFIDX_WIDTH = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [RFIDX_WIDTH-1:0] id_rs1_index,
  input  logic [RFIDX_WIDTH-1:0] id_rs2_index,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [RFIDX_WIDTH-1:0] ex_rd_index,
  input  logic                   ex_mem_read,
  input  logic                   ex_branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   if_id_flush,
  output logic                   id_ex_en,
  output logic                   id_ex_flush,
  output logic                   ex_mem_en,
  output logic                   mem_wb_flush,
  output logic                   mem_timeout,
  output logic [CNT_WIDTH-1:0]   stall_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [WAIT_W-1:0]     wait_cnt_r;
  logic [WAIT_W-1:0]     wait_cnt_nxt_s;
  logic                  mem_timeout_r;
  logic [CNT_WIDTH-1:0]  stall_cnt_r;
  logic                  lu_s;
  logic                  ms_s;

  // x0 is never a real producer, so a load targeting it cannot create a hazard
  assign lu_s = ex_mem_read && (ex_rd_index != {RFIDX_WIDTH{1'b0}}) &&
                ((id_rs1_used && (id_rs1_index == ex_rd_index)) ||
                 (id_rs2_used && (id_rs2_index == ex_rd_index)));
  assign ms_s = mem_req && !mem_ready && (state_r != ST_HALT);

  assign mem_timeout = mem_timeout_r;
  assign stall_cnt   = stall_cnt_r;

  // State and wait-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= {WAIT_W{1'b0}};
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      wait_cnt_r    <= wait_cnt_nxt_s;
      mem_timeout_r <= (state_nxt_s == ST_HALT);
    end
  end

  // Next-state decode; wait_cnt counts stalled cycles already spent in the current wait
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (ms_s) begin
          state_nxt_s    = ST_MEM_WAIT;
          wait_cnt_nxt_s = {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
          state_nxt_s    = ST_RUN;
          wait_cnt_nxt_s = {WAIT_W{1'b0}};
        end
      end
      ST_MEM_WAIT: begin
        if (ms_s) begin
          if (wait_cnt_r == WAIT_LAST) begin
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s    = ST_MEM_WAIT;
            wait_cnt_nxt_s = wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_nxt_s    = ST_RUN;
          wait_cnt_nxt_s = {WAIT_W{1'b0}};
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s    = ST_RUN;
        wait_cnt_nxt_s = {WAIT_W{1'b0}};
      end
    endcase
  end

  // Pipeline control decode in priority order; reset forces bubbles everywhere
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_flush = 1'b0;
    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_en     = 1'b0;
      id_ex_flush  = 1'b1;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (state_r == ST_HALT) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
    end else if (ms_s) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (lu_s) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_flush  = 1'b1;
    end else begin
      pc_en        = 1'b1;
    end
  end

  // Saturating count of frozen-PC cycles outside HALT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (!pc_en && (state_r != ST_HALT) && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl with MEM_TIMEOUT=4 and CNT_WIDTH=4.
module tb_pipe_ctrl;
  localparam int RW = 5;
  localparam int TO = 4;
  localparam int CW = 4;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}
  localparam logic [6:0] NORM = 7'b1101010;
  localparam logic [6:0] LU   = 7'b0001110;
  localparam logic [6:0] BR   = 7'b1111110;
  localparam logic [6:0] MS   = 7'b0000001;
  localparam logic [6:0] HLT  = 7'b0000000;
  localparam logic [6:0] RST  = 7'b0010101;

  logic clk = 1'b0;
  logic rst_n;
  logic [RW-1:0] id_rs1_index, id_rs2_index, ex_rd_index;
  logic id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
  logic mem_timeout;
  logic [CW-1:0] stall_cnt;
  logic [6:0] ctrl;

  typedef struct {
    logic [6:0]    ctrl;
    logic [CW-1:0] cnt;
    logic          to;
    string         tag;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush};

  pipe_ctrl #(.RFIDX_WIDTH(RW), .MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_index(ex_rd_index), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_flush(mem_wb_flush), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  task automatic drive(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2, input logic u1,
                       input logic u2, input logic [RW-1:0] rd, input logic mr, input logic br,
                       input logic req, input logic rdy);
    id_rs1_index = rs1; id_rs2_index = rs2; id_rs1_used = u1; id_rs2_used = u2;
    ex_rd_index = rd; ex_mem_read = mr; ex_branch_taken = br; mem_req = req; mem_ready = rdy;
  endtask

  task automatic push_exp(input logic [6:0] c, input logic [CW-1:0] n, input logic t,
                          input string tag);
    exp_t e;
    e.ctrl = c; e.cnt = n; e.to = t; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    n_tests++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard: got empty queue, want one entry");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      assert (ctrl === e.ctrl) else begin
        n_fail++;
        $error("FAIL %s ctrl: got %b want %b", e.tag, ctrl, e.ctrl);
      end
      n_tests++;
      assert (stall_cnt === e.cnt) else begin
        n_fail++;
        $error("FAIL %s stall_cnt: got %0d want %0d", e.tag, stall_cnt, e.cnt);
      end
      n_tests++;
      assert (mem_timeout === e.to) else begin
        n_fail++;
        $error("FAIL %s mem_timeout: got %b want %b", e.tag, mem_timeout, e.to);
      end
    end
  endtask

  // Drive one cycle at the falling edge, check before the rising edge, then advance.
  task automatic step(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2, input logic u1,
                      input logic u2, input logic [RW-1:0] rd, input logic mr, input logic br,
                      input logic req, input logic rdy, input logic [6:0] c,
                      input logic [CW-1:0] n, input logic t, input string tag);
    drive(rs1, rs2, u1, u2, rd, mr, br, req, rdy);
    push_exp(c, n, t, tag);
    #1;
    compare();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp(RST, 4'd0, 1'b0, "reset");
    #2;
    compare();
    @(negedge clk);
    rst_n = 1'b1;

    step(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 4'd0, 1'b0, "idle");
    step(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU,   4'd0, 1'b0, "lu_rs2");
    step(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 4'd1, 1'b0, "lu_after");
    step(5'd0, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NORM, 4'd1, 1'b0, "rd_x0");
    step(5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, NORM, 4'd1, 1'b0, "rs1_unused");
    step(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LU,   4'd1, 1'b0, "lu_rs1");
    step(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, BR,   4'd2, 1'b0, "br_over_lu");
    step(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 4'd2, 1'b0, "br_no_stall");

    // three not-ready cycles with a taken branch waiting in EX
    for (int i = 0; i < 3; i++) begin
      step(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, MS, 4'(2 + i), 1'b0, "mem_wait");
    end
    step(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, BR,   4'd5, 1'b0, "mem_release_br");
    step(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, NORM, 4'd5, 1'b0, "mem_first_ready");
    step(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 4'd5, 1'b0, "idle2");
    step(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, MS,   4'd5, 1'b0, "req_drop_a");
    step(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 4'd6, 1'b0, "req_drop_b");
    step(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, MS,   4'd6, 1'b0, "wait_pre_rst");
    step(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, MS,   4'd7, 1'b0, "wait_pre_rst");

    // asynchronous reset in the middle of a memory wait
    #2;
    rst_n = 1'b0;
    push_exp(RST, 4'd0, 1'b0, "rst_mid_wait");
    #1;
    compare();
    @(negedge clk);
    rst_n = 1'b1;

    // timeout: four consecutive stalled cycles then HALT
    for (int i = 0; i < TO; i++) begin
      step(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, MS, 4'(i), 1'b0, "timeout_wait");
    end
    step(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, HLT, 4'd4, 1'b1, "halt");
    step(5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, HLT, 4'd4, 1'b1, "halt_sticky");

    // asynchronous reset out of HALT
    #2;
    rst_n = 1'b0;
    push_exp(RST, 4'd0, 1'b0, "rst_halt");
    #1;
    compare();
    @(negedge clk);
    rst_n = 1'b1;

    // saturation of the 4-bit stall counter
    for (int i = 0; i < 20; i++) begin
      step(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, LU,
           (i < 15) ? 4'(i) : 4'd15, 1'b0, "saturate");
    end
    step(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 4'd15, 1'b0, "sat_hold");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard and stall controller for the 5-stage core. It watches the ID stage, the ID/EX register outputs and the data-memory handshake. From these it generates the enable and flush controls for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It inserts load-use bubbles, squashes wrong-path instructions on taken branches, freezes the pipe while data memory is busy, and halts the core on a memory timeout.

## Interface

Parameters:
- RFIDX_WIDTH, 5: register index width.
- MEM_TIMEOUT, 16: consecutive memory-wait cycles before halt. Legal range is 2 to 2^CNT_WIDTH-1.
- CNT_WIDTH, 32: width of the stall performance counter.

Ports:
- clk  in  1  single core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_rs1_index  in  RFIDX_WIDTH  rs1 index of the instruction in ID.
- id_rs2_index  in  RFIDX_WIDTH  rs2 index of the instruction in ID.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- ex_rd_index  in  RFIDX_WIDTH  rd of the instruction in EX (ID/EX output).
- ex_mem_read  in  1  EX instruction is a load (ID/EX output).
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- mem_req  in  1  MEM-stage instruction accesses data memory this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads a bubble.
- id_ex_en  out  1  ID/EX load enable.
- id_ex_flush  out  1  ID/EX loads a bubble (all control bits 0).
- ex_mem_en  out  1  EX/MEM load enable.
- mem_wb_flush  out  1  MEM/WB loads a bubble.
- mem_timeout  out  1  sticky halt flag.
- stall_cnt  out  CNT_WIDTH  count of cycles in which pc_en was 0, excluding HALT.

## Operation

- A flush overrides the corresponding enable: the register loads a bubble at the next edge.
- States are RUN, MEM_WAIT and HALT. A wait counter wait_cnt of ceil(log2(MEM_TIMEOUT+1)) bits is kept alongside.
- A load-use hazard (lu) is: ex_mem_read AND ex_rd_index != 0 AND ((id_rs1_used AND rs1 matches) OR (id_rs2_used AND rs2 matches)).
- A memory stall (ms) is: mem_req AND NOT mem_ready, while in RUN or MEM_WAIT.

Priority of the condition decode, highest first:
- HALT: every enable is 0 and every flush is 0; the pipe is frozen.
- ms: pc_en, if_id_en, id_ex_en and ex_mem_en are all 0, and mem_wb_flush=1. A taken branch or lu is ignored because EX is held and re-evaluated later.
- ex_branch_taken: all enables are 1, if_id_flush=1 and id_ex_flush=1. lu is ignored because the ID instruction is squashed.
- lu: pc_en=0, if_id_en=0, id_ex_flush=1 and ex_mem_en=1, giving exactly one bubble.
- Otherwise all enables are 1 and all flushes are 0.

State transitions:
- RUN to MEM_WAIT on ms, with wait_cnt set to 1.
- MEM_WAIT stays in MEM_WAIT while ms, incrementing wait_cnt.
- MEM_WAIT to RUN when mem_ready. That same cycle is unstalled.
- MEM_WAIT to HALT when ms and wait_cnt == MEM_TIMEOUT-1. This means MEM_TIMEOUT consecutive stalled cycles occurred.
- If mem_req drops while in MEM_WAIT, the block returns to RUN.
- HALT is left only by reset. mem_timeout=1 in HALT.

stall_cnt:
- Increments when pc_en==0 and the state is not HALT.
- Saturates at all-ones.

## Timing

- Control outputs are combinational from the current state and inputs, with no added latency. State, wait_cnt, stall_cnt and mem_timeout are registered.
- While rst_n=0 (asynchronous):
  - state=RUN, wait_cnt=0, stall_cnt=0, mem_timeout=0;
  - pc_en, if_id_en, id_ex_en and ex_mem_en are 0;
  - if_id_flush, id_ex_flush and mem_wb_flush are 1.
- On the first edge after rst_n rises, normal decode applies.
- A load-use bubble costs exactly 1 cycle. The load then sits in MEM, lu clears, and the dependent instruction re-decodes.
- A taken branch costs 2 bubbles. The PC loads the target at the same edge.
- Memory wait:
  - A first-cycle ready (mem_req and mem_ready together) costs 0 stall cycles.
  - Each not-ready cycle costs 1 stall cycle.
  - HALT is entered at the edge ending the MEM_TIMEOUT-th stalled cycle.
- Reset asserted mid-MEM_WAIT or in HALT returns the block to RUN immediately. The counters clear.

## Test plan

- Load x5 in EX (ex_mem_read=1, ex_rd_index=5), ID uses rs2=5:
  - pc_en=0, if_id_en=0, id_ex_flush=1 for 1 cycle;
  - the next cycle is all-enable;
  - stall_cnt=1.
- ex_rd_index=0 with ex_mem_read=1 and ID rs1=0 used: no stall. Also, a matching index with id_rs1_used=0: no stall.
- ex_branch_taken=1 in the same cycle as a load-use match:
  - if_id_flush=1 and id_ex_flush=1, pc_en=1;
  - stall_cnt is unchanged.
- mem_req=1, mem_ready=0 for 3 cycles, then ready:
  - enables are 0 for 3 cycles with mem_wb_flush=1;
  - the block returns to RUN;
  - stall_cnt=3;
  - a ex_branch_taken held during the wait is acted on in the release cycle.
- MEM_TIMEOUT=4 with mem_ready stuck at 0:
  - after 4 stalled cycles mem_timeout=1 and the state is HALT;
  - all enables stay 0 and stall_cnt stays 4;
  - asserting rst_n=0 clears mem_timeout and stall_cnt to 0 asynchronously.
- Saturation with CNT_WIDTH=4: force 20 lu cycles; stall_cnt stops at 15.
